// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// the FSM state type, the widest supported pattern and the masked compare.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int PAT_LEN_MAX = 32;

   // Zero bits in mask are don't-care positions. Callers zero-extend
   // narrower patterns, so the unused upper bits always compare equal.
   function automatic logic masked_match(input logic [PAT_LEN_MAX-1:0] data,
                                         input logic [PAT_LEN_MAX-1:0] pattern,
                                         input logic [PAT_LEN_MAX-1:0] mask);
      return ((data ^ pattern) & mask) == '0;
   endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter used for the detector's match count.
// A clear wins over a simultaneous increment; the count never wraps.
module seq_det_sat_cnt
   import seq_det_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Count register: clear first, then increment unless already at all-ones
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial sync-word detector with runtime pattern and overlap mode.
// Bits are qualified by in_valid; a hit produces a registered one-cycle match
// pulse and bumps a saturating match counter.
// Optional build macro SEQ_DET_MASK_EN adds a cfg_mask port whose zero bits
// make the corresponding pattern positions don't-care.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic               cfg_load,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
   input  logic [PAT_LEN-1:0] cfg_mask,
`endif
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

   state_t             state, state_nxt;
   logic [PAT_LEN-1:0] hist, hist_nxt, nhist;
   logic [PAT_LEN-1:0] pat_q, pat_nxt;
   logic [PAT_LEN-1:0] mask_eff;
   logic [FILL_W-1:0]  fill, fill_nxt, nfill;
   logic               ovl_q, ovl_nxt;
   logic               match_nxt;
   logic               accept;
   logic               hit;

`ifdef SEQ_DET_MASK_EN
   logic [PAT_LEN-1:0] mask_q, mask_nxt;
   assign mask_eff = mask_q;
`else
   assign mask_eff = '1;
`endif

   assign busy = (state != IDLE);

   // Next-state, history, fill level, config latching and match decision
   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill;
      pat_nxt   = pat_q;
      ovl_nxt   = ovl_q;
`ifdef SEQ_DET_MASK_EN
      mask_nxt  = mask_q;
`endif
      match_nxt = 1'b0;

      accept = en && in_valid && ((state == FILL) || (state == RUN));
      nhist  = (hist << 1) | PAT_LEN'(in_bit);
      nfill  = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
      hit    = accept && (nfill == FILL_FULL) &&
               masked_match(PAT_LEN_MAX'(nhist), PAT_LEN_MAX'(pat_q),
                            PAT_LEN_MAX'(mask_eff));

      case (state)
         IDLE: begin
            if (cfg_load) begin
               pat_nxt  = cfg_pattern;
               ovl_nxt  = cfg_overlap;
`ifdef SEQ_DET_MASK_EN
               mask_nxt = cfg_mask;
`endif
            end
            if (en) begin
               state_nxt = FILL;
            end
         end
         FILL, RUN: begin
            if (!en) begin
               state_nxt = IDLE;
               hist_nxt  = '0;
               fill_nxt  = '0;
            end else if (accept) begin
               match_nxt = hit;
               if (hit && !ovl_q) begin
                  state_nxt = FILL;
                  hist_nxt  = '0;
                  fill_nxt  = '0;
               end else begin
                  hist_nxt  = nhist;
                  fill_nxt  = nfill;
                  state_nxt = (nfill == FILL_FULL) ? RUN : FILL;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            hist_nxt  = '0;
            fill_nxt  = '0;
         end
      endcase
   end

   // State, history, configuration and registered match pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         hist   <= '0;
         fill   <= '0;
         pat_q  <= '0;
         ovl_q  <= 1'b0;
`ifdef SEQ_DET_MASK_EN
         mask_q <= '1;
`endif
         match  <= 1'b0;
      end else begin
         state  <= state_nxt;
         hist   <= hist_nxt;
         fill   <= fill_nxt;
         pat_q  <= pat_nxt;
         ovl_q  <= ovl_nxt;
`ifdef SEQ_DET_MASK_EN
         mask_q <= mask_nxt;
`endif
         match  <= match_nxt;
      end
   end

   seq_det_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (hit),
      .clr  (cnt_clr),
      .cnt  (match_cnt)
   );

endmodule
